// File: rtl/bus_master_if.sv
// Master-side bus between bus_master and a crossbar port.
// The master drives the request, command, address and write data; the slave returns ack and read data.
interface bus_master_if;
    logic        req;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, cmd, wdata, input  ack, rdata);
    modport slave  (input  req, addr, cmd, wdata, output ack, rdata);
endinterface

// File: rtl/bus_master.sv
// Bus exerciser: writes NUM_TXN incrementing words over an address window, reads each back,
// counts mismatches and flags ack timeouts.
module bus_master #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'h8000_0001,
    parameter int unsigned NUM_TXN   = 16,
    parameter logic [31:0] SEED      = 32'h1111_1111,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    bus_master_if.master bus,
    output logic         busy,
    output logic         done,
    output logic [15:0]  err_cnt,
    output logic         timeout
);

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_DATA, DONE} state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_TXN - 1);
    localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] err_q, err_d;
    logic        tmo_q, tmo_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= ADDR_BASE;
            wdata_q <= SEED;
            idx_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = '0;
                    tmo_d   = 1'b0;
                    idx_d   = '0;
                    wait_d  = '0;
                    addr_d  = ADDR_BASE;
                    wdata_d = SEED;
                    state_d = WR_REQ;
                end
            end
            // ack is tested before expiry so a last-cycle ack still completes the request
            WR_REQ, RD_REQ: begin
                if (bus.ack) begin
                    wait_d  = '0;
                    state_d = (state_q == WR_REQ) ? RD_REQ : RD_DATA;
                end else if (wait_q == WAIT_MAX) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            RD_DATA: begin
                if ((bus.rdata != wdata_q) && (err_q != '1)) begin
                    err_d = err_q + 16'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    addr_d  = addr_q + ADDR_STEP;
                    wdata_d = wdata_q + 32'd1;
                    wait_d  = '0;
                    state_d = WR_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req   = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign bus.cmd   = (state_q == WR_REQ);
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign busy      = (state_q == WR_REQ) || (state_q == RD_REQ) || (state_q == RD_DATA);
    assign done      = (state_q == DONE);
    assign err_cnt   = err_q;
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_bus_master.sv
// Randomized bench for bus_master: two instances (default-style window and wrap-around window)
// driven by behavioural slaves, checked against a closed-form model of addresses, data and timing.
`timescale 1ns/1ps
module tb_bus_master;

    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] STEP_A = 32'h8000_0001;
    localparam logic [31:0] SEED_A = 32'h1111_1111;
    localparam int unsigned N_A    = 4;
    localparam int unsigned TMO_A  = 8;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFFF;
    localparam logic [31:0] STEP_B = 32'h0000_0001;
    localparam logic [31:0] SEED_B = 32'hFFFF_FFFF;
    localparam int unsigned N_B    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, done_a, tmo_a, busy_b, done_b, tmo_b;
    logic [15:0] err_a, err_b;
    int unsigned checks = 0, errors = 0;

    bus_master_if ifa ();
    bus_master_if ifb ();

    bus_master #(.ADDR_BASE(BASE_A), .ADDR_STEP(STEP_A), .NUM_TXN(N_A), .SEED(SEED_A), .TIMEOUT(TMO_A))
    dut_a (.clk(clk), .reset(reset), .start(start_a), .bus(ifa),
           .busy(busy_a), .done(done_a), .err_cnt(err_a), .timeout(tmo_a));

    bus_master #(.ADDR_BASE(BASE_B), .ADDR_STEP(STEP_B), .NUM_TXN(N_B), .SEED(SEED_B), .TIMEOUT(TMO_A))
    dut_b (.clk(clk), .reset(reset), .start(start_b), .bus(ifb),
           .busy(busy_b), .done(done_b), .err_cnt(err_b), .timeout(tmo_b));

    always #5 clk = ~clk;

    // Slave A: per-request ack delay table, optional read corruption, stray acks while req is low
    int unsigned dly_a [0:15];
    logic [15:0] corrupt_a = '0;
    bit          ack_en_a = 1'b1, stray_en_a = 1'b0;
    logic        stray_a = 1'b0;
    int unsigned wcnt_a = 0, ack_n_a = 0, ack_base_a = 0, rd_n_a = 0, rd_base_a = 0;
    logic [31:0] last_wa_a = '0, last_wd_a = '0;
    logic [31:0] wa_a[$], wd_a[$];

    assign ifa.ack = ifa.req ? (ack_en_a && (wcnt_a >= dly_a[4'(ack_n_a - ack_base_a)])) : stray_a;

    always @(posedge clk) begin
        stray_a <= stray_en_a && ($urandom_range(0, 1) == 1);
        if (ifa.req && ifa.ack) begin
            wcnt_a  <= 0;
            ack_n_a <= ack_n_a + 1;
            if (ifa.cmd) begin
                last_wa_a <= ifa.addr;
                last_wd_a <= ifa.wdata;
                wa_a.push_back(ifa.addr);
                wd_a.push_back(ifa.wdata);
            end else begin
                rd_n_a    <= rd_n_a + 1;
                ifa.rdata <= ((ifa.addr == last_wa_a) ? last_wd_a : ~last_wd_a)
                             ^ (corrupt_a[4'(rd_n_a - rd_base_a)] ? 32'h0000_0100 : 32'h0);
            end
        end else if (ifa.req) begin
            wcnt_a <= wcnt_a + 1;
        end else begin
            wcnt_a <= 0;
        end
    end

    // Slave B: zero-wait echo
    logic [31:0] last_wa_b = '0, last_wd_b = '0;
    logic [31:0] wa_b[$], wd_b[$];
    assign ifb.ack = ifb.req;
    always @(posedge clk) begin
        if (ifb.req && ifb.cmd) begin
            last_wa_b <= ifb.addr;
            last_wd_b <= ifb.wdata;
            wa_b.push_back(ifb.addr);
            wd_b.push_back(ifb.wdata);
        end else if (ifb.req) begin
            ifb.rdata <= (ifb.addr == last_wa_b) ? last_wd_b : ~last_wd_b;
        end
    end

    int unsigned busy_cyc_a = 0, req_cyc_a = 0, done_n_a = 0, done_n_b = 0;
    always @(posedge clk) begin
        busy_cyc_a <= busy_cyc_a + (busy_a ? 1 : 0);
        req_cyc_a  <= req_cyc_a + (ifa.req ? 1 : 0);
        done_n_a   <= done_n_a + (done_a ? 1 : 0);
        done_n_b   <= done_n_b + (done_b ? 1 : 0);
    end

    function automatic logic [31:0] model_addr(input logic [31:0] base, input logic [31:0] step,
                                               input int unsigned k);
        return base + step * 32'(k);
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] seed, input int unsigned k);
        return seed + 32'(k);
    endfunction

    // Stimulus only: one run on instance A, returns observations for the calling test to judge
    task automatic do_run_a(input int unsigned max_cyc, output bit seen, output int unsigned wbase,
                            output int unsigned bcyc, output int unsigned rcyc, output int unsigned ndone);
        int unsigned b0, r0, d0;
        ack_base_a = ack_n_a;
        rd_base_a  = rd_n_a;
        wbase = wa_a.size();
        b0 = busy_cyc_a; r0 = req_cyc_a; d0 = done_n_a;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        seen = 1'b0;
        for (int unsigned c = 0; c < max_cyc; c++) begin
            if (done_a) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        bcyc = busy_cyc_a - b0; rcyc = req_cyc_a - r0; ndone = done_n_a - d0;
    endtask

    task automatic test_reset();
        logic [84:0] obs, expv;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        obs  = {ifa.req, ifa.cmd, busy_a, done_a, tmo_a, err_a, ifa.addr, ifa.wdata};
        expv = {5'b0, 16'h0, BASE_A, SEED_A};
        if (obs !== expv) begin errors++; $display("FAIL reset_hold_a got %h exp %h", obs, expv); end
        checks++;
        obs  = {ifb.req, ifb.cmd, busy_b, done_b, tmo_b, err_b, ifb.addr, ifb.wdata};
        expv = {5'b0, 16'h0, BASE_B, SEED_B};
        if (obs !== expv) begin errors++; $display("FAIL reset_hold_b got %h exp %h", obs, expv); end
        reset = 1'b1;
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            obs  = {ifa.req, ifa.cmd, busy_a, done_a, tmo_a, err_a, ifa.addr, ifa.wdata};
            expv = {5'b0, 16'h0, BASE_A, SEED_A};
            if (obs !== expv) begin errors++; $display("FAIL reset_idle_a cyc %0d got %h exp %h", c, obs, expv); end
            checks++;
            obs  = {ifb.req, ifb.cmd, busy_b, done_b, tmo_b, err_b, ifb.addr, ifb.wdata};
            expv = {5'b0, 16'h0, BASE_B, SEED_B};
            if (obs !== expv) begin errors++; $display("FAIL reset_idle_b cyc %0d got %h exp %h", c, obs, expv); end
        end
    endtask

    task automatic test_zero_wait();
        bit seen; int unsigned wb, bc, rc, nd;
        for (int i = 0; i < 16; i++) dly_a[i] = 0;
        corrupt_a = '0; ack_en_a = 1'b1; stray_en_a = 1'b0;
        do_run_a(100, seen, wb, bc, rc, nd);
        checks++; if (!seen) begin errors++; $display("FAIL zw_done_seen got 0 exp 1"); end
        checks++; if (bc !== 12) begin errors++; $display("FAIL zw_latency got %0d exp 12", bc); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL zw_done_pulses got %0d exp 1", nd); end
        checks++;
        if ({done_a, busy_a, tmo_a, err_a} !== 19'h0) begin
            errors++; $display("FAIL zw_end_state got done=%b busy=%b tmo=%b err=%0d exp 0", done_a, busy_a, tmo_a, err_a);
        end
        checks++;
        if (wa_a.size() - wb !== N_A) begin errors++; $display("FAIL zw_write_count got %0d exp %0d", wa_a.size() - wb, N_A); end
        for (int unsigned k = 0; k < N_A && wb + k < wa_a.size(); k++) begin
            checks++;
            if (wa_a[wb + k] !== model_addr(BASE_A, STEP_A, k) || wd_a[wb + k] !== model_data(SEED_A, k)) begin
                errors++;
                $display("FAIL zw_write%0d got %h/%h exp %h/%h", k, wa_a[wb + k], wd_a[wb + k],
                         model_addr(BASE_A, STEP_A, k), model_data(SEED_A, k));
            end
        end
    endtask

    task automatic test_corrupt();
        bit seen; int unsigned wb, bc, rc, nd;
        for (int i = 0; i < 16; i++) dly_a[i] = 0;
        corrupt_a = 16'b0100;
        do_run_a(100, seen, wb, bc, rc, nd);
        corrupt_a = '0;
        checks++; if (!seen || nd !== 1) begin errors++; $display("FAIL corrupt_done got seen=%b pulses=%0d exp 1/1", seen, nd); end
        checks++; if (err_a !== 16'd1) begin errors++; $display("FAIL corrupt_err_cnt got %0d exp 1", err_a); end
        checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL corrupt_timeout got %b exp 0", tmo_a); end
        checks++; if (wa_a.size() - wb !== N_A) begin errors++; $display("FAIL corrupt_writes got %0d exp %0d", wa_a.size() - wb, N_A); end
    endtask

    task automatic test_random();
        bit seen; int unsigned wb, bc, rc, nd, exp_b; logic [15:0] exp_err; bit idle_bad;
        stray_en_a = 1'b1;
        for (int r = 0; r < 6; r++) begin
            exp_b = N_A;
            for (int i = 0; i < 16; i++) begin
                dly_a[i] = $urandom_range(0, TMO_A - 1);
                if (i < 2 * N_A) exp_b += dly_a[i] + 1;
            end
            corrupt_a = 16'($urandom_range(0, 15));
            exp_err = 16'($countones(corrupt_a[3:0]));
            do_run_a(300, seen, wb, bc, rc, nd);
            checks++; if (!seen || nd !== 1) begin errors++; $display("FAIL rnd%0d_done got seen=%b pulses=%0d exp 1/1", r, seen, nd); end
            checks++; if (bc !== exp_b) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", r, bc, exp_b); end
            checks++; if (err_a !== exp_err) begin errors++; $display("FAIL rnd%0d_err_cnt got %0d exp %0d", r, err_a, exp_err); end
            checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got %b exp 0", r, tmo_a); end
            checks++; if (wa_a.size() - wb !== N_A) begin errors++; $display("FAIL rnd%0d_writes got %0d exp %0d", r, wa_a.size() - wb, N_A); end
            for (int unsigned k = 0; k < N_A && wb + k < wa_a.size(); k++) begin
                checks++;
                if (wa_a[wb + k] !== model_addr(BASE_A, STEP_A, k) || wd_a[wb + k] !== model_data(SEED_A, k)) begin
                    errors++; $display("FAIL rnd%0d_write%0d got %h/%h", r, k, wa_a[wb + k], wd_a[wb + k]);
                end
            end
        end
        idle_bad = 1'b0;
        exp_err = err_a;
        repeat (12) begin
            @(negedge clk);
            if (ifa.req || busy_a || err_a !== exp_err) idle_bad = 1'b1;
        end
        stray_en_a = 1'b0;
        corrupt_a = '0;
        checks++; if (idle_bad) begin errors++; $display("FAIL stray_ack_idle got activity exp none"); end
    endtask

    task automatic test_timeout();
        bit seen; int unsigned wb, bc, rc, nd;
        for (int i = 0; i < 16; i++) dly_a[i] = 0;
        ack_en_a = 1'b0;
        do_run_a(60, seen, wb, bc, rc, nd);
        ack_en_a = 1'b1;
        checks++; if (rc !== TMO_A) begin errors++; $display("FAIL tmo_req_cycles got %0d exp %0d", rc, TMO_A); end
        checks++; if (!seen || nd !== 1) begin errors++; $display("FAIL tmo_done got seen=%b pulses=%0d exp 1/1", seen, nd); end
        checks++; if (tmo_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL tmo_flag got tmo=%b busy=%b exp 1/0", tmo_a, busy_a); end
        repeat (5) @(negedge clk);
        checks++; if (tmo_a !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", tmo_a); end
        // ack on the last allowed wait cycle
        dly_a[0] = TMO_A - 1;
        do_run_a(100, seen, wb, bc, rc, nd);
        checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL tmo_ack_wins got %b exp 0", tmo_a); end
        checks++; if (bc !== 12 + TMO_A - 1) begin errors++; $display("FAIL tmo_ack_wins_latency got %0d exp %0d", bc, 12 + TMO_A - 1); end
        checks++; if (wa_a.size() - wb !== N_A) begin errors++; $display("FAIL tmo_ack_wins_writes got %0d exp %0d", wa_a.size() - wb, N_A); end
        // read of pair 0 waits one cycle too long
        dly_a[0] = 0; dly_a[1] = TMO_A;
        do_run_a(100, seen, wb, bc, rc, nd);
        dly_a[1] = 0;
        checks++; if (rc !== 1 + TMO_A) begin errors++; $display("FAIL tmo_read_req_cycles got %0d exp %0d", rc, 1 + TMO_A); end
        checks++; if (tmo_a !== 1'b1 || err_a !== 16'd0 || nd !== 1) begin
            errors++; $display("FAIL tmo_read got tmo=%b err=%0d pulses=%0d exp 1/0/1", tmo_a, err_a, nd);
        end
    endtask

    task automatic test_start_ignored();
        int unsigned wb, b0, d0, exp_b; bit seen;
        for (int i = 0; i < 16; i++) dly_a[i] = 2;
        exp_b = N_A + 2 * N_A * 3;
        ack_base_a = ack_n_a; rd_base_a = rd_n_a;
        wb = wa_a.size(); b0 = busy_cyc_a; d0 = done_n_a;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        seen = 1'b0;
        for (int unsigned c = 0; c < 200; c++) begin
            if (done_a) begin seen = 1'b1; break; end
            start_a = (c == 4 || c == 11);
            @(negedge clk);
        end
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (!seen || done_n_a - d0 !== 1) begin errors++; $display("FAIL restart_done got seen=%b pulses=%0d exp 1/1", seen, done_n_a - d0); end
        checks++; if (busy_cyc_a - b0 !== exp_b) begin errors++; $display("FAIL restart_latency got %0d exp %0d", busy_cyc_a - b0, exp_b); end
        checks++; if (busy_a !== 1'b0 || wa_a.size() - wb !== N_A) begin
            errors++; $display("FAIL restart_ignored got busy=%b writes=%0d exp 0/%0d", busy_a, wa_a.size() - wb, N_A);
        end
        for (int i = 0; i < 16; i++) dly_a[i] = 0;
    endtask

    task automatic test_wrap();
        int unsigned wb; bit seen;
        wb = wa_b.size();
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        seen = 1'b0;
        for (int unsigned c = 0; c < 40; c++) begin
            if (done_b) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        checks++; if (!seen || err_b !== 16'd0 || tmo_b !== 1'b0) begin
            errors++; $display("FAIL wrap_run got seen=%b err=%0d tmo=%b exp 1/0/0", seen, err_b, tmo_b);
        end
        checks++; if (wa_b.size() - wb !== N_B) begin errors++; $display("FAIL wrap_writes got %0d exp %0d", wa_b.size() - wb, N_B); end
        for (int unsigned k = 0; k < N_B && wb + k < wa_b.size(); k++) begin
            checks++;
            if (wa_b[wb + k] !== model_addr(BASE_B, STEP_B, k) || wd_b[wb + k] !== model_data(SEED_B, k)) begin
                errors++;
                $display("FAIL wrap_write%0d got %h/%h exp %h/%h", k, wa_b[wb + k], wd_b[wb + k],
                         model_addr(BASE_B, STEP_B, k), model_data(SEED_B, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found, seen; int unsigned d0, r0, wb, bc, rc, nd;
        for (int i = 0; i < 16; i++) dly_a[i] = 0;
        dly_a[1] = 5;
        ack_base_a = ack_n_a; rd_base_a = rd_n_a;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        found = 1'b0;
        for (int unsigned c = 0; c < 20; c++) begin
            if (ifa.req && !ifa.cmd) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach_rd_req got 0 exp 1"); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({ifa.req, busy_a, done_a, err_a} !== 19'h0 || ifa.addr !== BASE_A) begin
            errors++; $display("FAIL abort_immediate got req=%b busy=%b done=%b err=%0d addr=%h exp 0/0/0/0/%h",
                               ifa.req, busy_a, done_a, err_a, ifa.addr, BASE_A);
        end
        d0 = done_n_a; r0 = req_cyc_a;
        @(negedge clk); reset = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (done_n_a - d0 !== 0 || req_cyc_a - r0 !== 0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL abort_no_resume got done=%0d req=%0d busy=%b exp 0/0/0", done_n_a - d0, req_cyc_a - r0, busy_a);
        end
        dly_a[1] = 0;
        do_run_a(100, seen, wb, bc, rc, nd);
        checks++; if (!seen || wa_a.size() - wb !== N_A || err_a !== 16'd0) begin
            errors++; $display("FAIL abort_restart got seen=%b writes=%0d err=%0d exp 1/%0d/0", seen, wa_a.size() - wb, N_A, err_a);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dly_a[i] = 0;
        test_reset();
        test_zero_wait();
        test_corrupt();
        test_random();
        test_timeout();
        test_start_ignored();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish before 200000ns");
        $fatal(1);
    end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, start address of the test window.
REQ-002 SHALL have parameter ADDR_STEP, default 32'h8000_0001, address increment per transaction pair.
REQ-003 SHALL have parameter NUM_TXN, default 16, number of write/read pairs per run (1..65535).
REQ-004 SHALL have parameter SEED, default 32'h1111_1111, write data of pair 0.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for ack (1..65535).
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1, one-cycle run request, sampled in IDLE only.
REQ-009 SHALL have port req, output, 1, bus request to crossbar master port.
REQ-010 SHALL have port addr, output, 32, bus address.
REQ-011 SHALL have port cmd, output, 1, 1 = write, 0 = read.
REQ-012 SHALL have port wdata, output, 32, write data.
REQ-013 SHALL have port ack, input, 1, one-cycle acceptance pulse from crossbar.
REQ-014 SHALL have port rdata, input, 32, read data, valid the cycle after a read ack.
REQ-015 SHALL have port busy, output, 1, high from start acceptance until DONE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at run end.
REQ-017 SHALL have port err_cnt, output, 16, read-back mismatch count of last run.
REQ-018 SHALL have port timeout, output, 1, sticky, set when an ack wait expired.

Function
REQ-019 SHALL implement states IDLE, WR_REQ, RD_REQ, RD_DATA, DONE.
REQ-020 IDLE: req=0; start=1 -> clear err_cnt, timeout, pair index i=0, load addr=ADDR_BASE, wdata=SEED, go WR_REQ next cycle.
REQ-021 WR_REQ: req=1, cmd=1, addr/wdata held stable until ack; ack=1 -> RD_REQ with same addr.
REQ-022 RD_REQ: req=1, cmd=0, addr held; ack=1 -> RD_DATA.
REQ-023 RD_DATA: req=0; compare rdata with wdata of pair i; mismatch -> err_cnt+1, saturating at 16'hFFFF.
REQ-024 RD_DATA exit: i=NUM_TXN-1 -> DONE; else i+1, addr+=ADDR_STEP (mod 2^32 wrap), wdata+=1 (mod 2^32 wrap), -> WR_REQ.
REQ-025 DONE: done=1 for exactly one cycle, busy=0 from this cycle, -> IDLE.
REQ-026 req SHALL deassert in the cycle following ack; no back-to-back re-request without passing through the next state.
REQ-027 Wait counter SHALL clear on entry to WR_REQ/RD_REQ and increment each cycle without ack; reaching TIMEOUT -> set timeout, req=0, -> DONE.
REQ-028 ack received in IDLE, RD_DATA or DONE SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-029 ack and timeout expiry in the same cycle: ack wins, no timeout set.
REQ-030 Per pair latency with zero-wait slave: WR_REQ 1 cycle + RD_REQ 1 cycle + RD_DATA 1 cycle = 3 cycles.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE, req=0, cmd=0, addr=ADDR_BASE, wdata=SEED, busy=0, done=0, err_cnt=0, timeout=0, i=0, wait counter=0.
REQ-032 reset asserted mid-transaction SHALL abort immediately; no done pulse; a new start is required after release.
REQ-033 First state change after reset release SHALL occur only on a rising clk edge.

Verification
REQ-034 Reset held, then released, no start -> all outputs at REQ-031 values for 20 cycles.
REQ-035 NUM_TXN=4, echo-memory slave ack same cycle -> writes 11111111..11111114 to 00000000, 80000001, 00000002, 80000003; err_cnt=0; done 12 cycles after WR_REQ entry.
REQ-036 Slave corrupts read of pair 2 -> err_cnt=1, timeout=0, done pulses once.
REQ-037 Slave never acks, TIMEOUT=8 -> req high 8 cycles, timeout=1, done pulse, busy=0.
REQ-038 ADDR_BASE=FFFF_FFFF, ADDR_STEP=1, SEED=FFFF_FFFF, NUM_TXN=2 -> pair 1 addr=0, wdata=0.
REQ-039 reset asserted during RD_REQ with ack pending -> req=0 immediately, no done, err_cnt=0.
